// File: rtl/permutation_scheduler.sv
// Ascon permutation scheduler: owns the 320-bit state register and round counter and
// steps an external combinational round datapath one round per clock.
module permutation_scheduler #(
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [319:0] state_i,
    input  logic [3:0]   nrounds_i,
    output logic [319:0] round_state_o,
    output logic [3:0]   round_o,
    input  logic [319:0] round_state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [319:0] state_o,
    output logic         err_o,
    output logic         busy_o
);

    localparam logic [3:0] MAX_R   = 4'(MAX_ROUNDS);
    localparam logic [3:0] LAST_R  = 4'(MAX_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm_reg;
    logic [319:0] state_reg;
    logic [3:0]   cnt_reg;
    logic         err_reg;
    logic         nrounds_legal;

    assign nrounds_legal = (nrounds_i != 4'd0) && (nrounds_i <= MAX_R);

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (in_valid_i) begin
                        state_reg <= state_i;
                        if (nrounds_legal) begin
                            cnt_reg <= MAX_R - nrounds_i;
                            fsm_reg <= RUN;
                        end else begin
                            // Illegal round count: hand the input straight back, flagged.
                            cnt_reg <= '0;
                            err_reg <= 1'b1;
                            fsm_reg <= DONE;
                        end
                    end
                end
                RUN: begin
                    state_reg <= round_state_i;
                    if (cnt_reg == LAST_R) begin
                        cnt_reg <= '0;
                        fsm_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        err_reg <= 1'b0;
                        fsm_reg <= IDLE;
                    end
                end
                default: begin
                    fsm_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o    = (fsm_reg == IDLE);
    assign out_valid_o   = (fsm_reg == DONE);
    assign busy_o        = (fsm_reg == RUN) || (fsm_reg == DONE);
    assign round_state_o = state_reg;
    assign round_o       = (fsm_reg == RUN) ? cnt_reg : 4'd0;
    // Intermediate round states never appear on the result port.
    assign state_o       = (fsm_reg == DONE) ? state_reg : '0;
    assign err_o         = err_reg;

endmodule

// File: tb/tb_permutation_scheduler.sv
// Bench for permutation_scheduler with an Ascon round model closing the datapath loop.
module tb_permutation_scheduler;

    localparam int MAXR = 12;

    logic         clk = 1'b0;
    logic         resetb;
    logic         in_valid;
    logic         in_ready;
    logic [319:0] state_in;
    logic [3:0]   nrounds;
    logic [319:0] round_state_o;
    logic [3:0]   round_o;
    logic [319:0] round_state_i;
    logic         out_valid;
    logic         out_ready;
    logic [319:0] state_out;
    logic         err;
    logic         busy;

    always #5 clk = ~clk;

    permutation_scheduler #(.MAX_ROUNDS(MAXR)) dut (
        .clock_i       (clk),
        .resetb_i      (resetb),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .state_i       (state_in),
        .nrounds_i     (nrounds),
        .round_state_o (round_state_o),
        .round_o       (round_o),
        .round_state_i (round_state_i),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .state_o       (state_out),
        .err_o         (err),
        .busy_o        (busy)
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [7:0]  c;
        x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
        c  = 8'hF0 - ({4'd0, r} * 8'h0F);
        x2 = x2 ^ {56'd0, c};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Golden datapath: reacts to whatever round index / state the scheduler presents.
    assign round_state_i = ascon_round(round_state_o, round_o);

    function automatic logic [319:0] model_perm(input logic [319:0] s, input logic [3:0] n);
        logic [319:0] r;
        r = s;
        for (int k = MAXR - int'(n); k < MAXR; k++) r = ascon_round(r, 4'(k));
        return r;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        logic [3:0]   nr;
        logic [319:0] st;
        int           bp;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    typedef struct {
        logic [319:0] st;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v);
        exp_t         e;
        int           k;
        int           busy_n;
        logic [319:0] exp_st;
        @(negedge clk);
        out_ready = (v.bp == 0);
        check("in_ready_idle", 320'(in_ready), 320'(1));
        in_valid = 1'b1;
        state_in = v.st;
        nrounds  = v.nr;
        exp_st   = v.exp_err ? v.st : model_perm(v.st, v.nr);
        sb_q.push_back('{st: exp_st, err: v.exp_err, lat: v.exp_lat});
        @(negedge clk);
        in_valid = 1'b0;
        state_in = rand320();
        nrounds  = 4'($urandom_range(0, 15));
        k = 0;
        busy_n = 0;
        while (!out_valid && k < 40) begin
            check("round_o", 320'(round_o), 320'(MAXR - int'(v.nr) + k));
            check("state_o_hidden", state_out, 320'(0));
            if (busy) busy_n++;
            @(negedge clk);
            k++;
        end
        e = sb_q.pop_front();
        if (k >= 40) begin
            tests++;
            failed++;
            $display("FAIL timeout: out_valid not seen after %0d cycles, required %0d", k, e.lat);
            return;
        end
        if (busy) busy_n++;
        check("latency", 320'(k), 320'(e.lat));
        check("state_o", state_out, e.st);
        check("err_o", 320'(err), 320'(e.err));
        check("round_o_done", 320'(round_o), 320'(0));
        $display("[TB] txn nrounds=%0d err=%0b latency=%0d state_o=%h", v.nr, err, k, state_out);
        if (v.bp > 0) begin
            for (int i = 0; i < v.bp; i++) begin
                in_valid = i[0];
                state_in = rand320();
                nrounds  = 4'd12;
                @(negedge clk);
                check("bp_out_valid", 320'(out_valid), 320'(1));
                check("bp_in_ready", 320'(in_ready), 320'(0));
                check("bp_state_o", state_out, e.st);
                check("bp_err_o", 320'(err), 320'(e.err));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end else begin
            check("busy_cycles", 320'(busy_n), 320'(e.lat + 1));
        end
        @(negedge clk);
        check("post_out_valid", 320'(out_valid), 320'(0));
        check("post_err", 320'(err), 320'(0));
        check("post_in_ready", 320'(in_ready), 320'(1));
        check("post_busy", 320'(busy), 320'(0));
    endtask

    vec_t         vecs[8];
    logic [319:0] kat;
    int           k;

    initial begin
        kat = {64'h80400c0600000000, 256'd0};
        vecs[0] = '{nr: 4'd12, st: kat,       bp: 0, exp_err: 1'b0, exp_lat: 12};
        vecs[1] = '{nr: 4'd6,  st: rand320(), bp: 0, exp_err: 1'b0, exp_lat: 6};
        vecs[2] = '{nr: 4'd8,  st: rand320(), bp: 0, exp_err: 1'b0, exp_lat: 8};
        vecs[3] = '{nr: 4'd0,  st: rand320(), bp: 0, exp_err: 1'b1, exp_lat: 0};
        vecs[4] = '{nr: 4'd13, st: rand320(), bp: 0, exp_err: 1'b1, exp_lat: 0};
        vecs[5] = '{nr: 4'd12, st: rand320(), bp: 5, exp_err: 1'b0, exp_lat: 12};
        vecs[6] = '{nr: 4'd15, st: rand320(), bp: 5, exp_err: 1'b1, exp_lat: 0};
        vecs[7] = '{nr: 4'd1,  st: rand320(), bp: 0, exp_err: 1'b0, exp_lat: 1};

        resetb    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        state_in  = '0;
        nrounds   = '0;
        #12;
        check("rst_in_ready", 320'(in_ready), 320'(1));
        check("rst_out_valid", 320'(out_valid), 320'(0));
        check("rst_busy", 320'(busy), 320'(0));
        check("rst_round_o", 320'(round_o), 320'(0));
        check("rst_state_o", state_out, 320'(0));
        check("rst_err", 320'(err), 320'(0));
        @(negedge clk);
        resetb = 1'b1;

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Reset in the middle of a 12-round run, at round index 4.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        state_in  = kat;
        nrounds   = 4'd12;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (round_o != 4'd4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mid_reset_reach_r4", 320'(k), 320'(4));
        resetb = 1'b0;
        #1;
        check("mid_reset_out_valid", 320'(out_valid), 320'(0));
        check("mid_reset_in_ready", 320'(in_ready), 320'(1));
        check("mid_reset_round_o", 320'(round_o), 320'(0));
        check("mid_reset_busy", 320'(busy), 320'(0));
        check("mid_reset_round_state", round_state_o, 320'(0));
        $display("[TB] txn mid-run reset at round 4");
        @(negedge clk);
        resetb = 1'b1;
        do_txn(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1);
    end

endmodule
